bin_mul: RTL and testbench

BIN_MUL -- requirements
Module: bin_mul

---
 rtl/bin_mul_pkg.sv | 5 +
 rtl/bin_mul_full_adder.sv | 11 +
 rtl/bin_mul.sv | 80 ++++++++
 tb/tb_bin_mul.sv | 106 ++++++++++
 4 files changed

// File: rtl/bin_mul_pkg.sv
// Shared widths for the 6x6 unsigned array multiplier.
package bin_mul_pkg;
  localparam int A_W = 6;
  localparam int P_W = 12;
endpackage

// File: rtl/bin_mul_full_adder.sv
// One-bit full adder cell used to build the multiplier array.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

// File: rtl/bin_mul.sv
// Registered 6x6 unsigned multiplier: input register, shift-and-add array of
// full adders, output register. Product appears one edge after sampling.
module bin_mul
  import bin_mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  output logic [P_W-1:0] product
);
  logic [A_W-1:0] a_q, b_q;
  logic [P_W-1:0] product_q, product_d;
  logic [A_W-1:0] pp [A_W];

  // Row gi of partial products: a weighted by b bit gi.
  genvar gi, gj;
  generate
    for (gi = 0; gi < A_W; gi++) begin : g_pp
      assign pp[gi] = a_q & {A_W{b_q[gi]}};
    end

    // Each row adds the previous row's sum (shifted right by one, with its
    // carry-out as the new MSB) to the next partial-product row.
    for (gi = 1; gi < A_W; gi++) begin : g_row
      for (gj = 0; gj < A_W; gj++) begin : g_col
        logic x, ci, s, co;
        if (gj == 0) begin : g_ci0
          assign ci = 1'b0;
        end else begin : g_cin
          assign ci = g_row[gi].g_col[gj-1].co;
        end

        if (gi == 1) begin : g_x0
          if (gj < A_W - 1) begin : g_xs
            assign x = pp[0][gj+1];
          end else begin : g_xz
            assign x = 1'b0;
          end
        end else begin : g_xn
          if (gj < A_W - 1) begin : g_xs
            assign x = g_row[gi-1].g_col[gj+1].s;
          end else begin : g_xc
            assign x = g_row[gi-1].g_col[A_W-1].co;
          end
        end

        full_adder u_fa (
          .x   (x),
          .y   (pp[gi][gj]),
          .cin (ci),
          .s   (s),
          .cout(co)
        );
      end
      assign product_d[gi] = g_row[gi].g_col[0].s;
    end

    for (gj = 1; gj < A_W; gj++) begin : g_hi
      assign product_d[A_W-1+gj] = g_row[A_W-1].g_col[gj].s;
    end
  endgenerate

  assign product_d[0]     = pp[0][0];
  assign product_d[P_W-1] = g_row[A_W-1].g_col[A_W-1].co;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      product_q <= product_d;
    end
  end

  assign product = product_q;
endmodule

// File: tb/tb_bin_mul.sv
// Scoreboard bench for bin_mul: stimulus queues expected products, a monitor
// pops and compares them two edges after the operands were driven.
module tb_bin_mul;
  logic        clk;
  logic        rst;
  logic [5:0]  a;
  logic [5:0]  b;
  logic [11:0] product;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q  [$];
  string       name_q [$];

  bin_mul dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs; one queue entry per edge. A reset edge
  // also kills the result still in flight from the previous edge.
  task automatic drive(input logic r, input logic [5:0] av, input logic [5:0] bv,
                       input logic [11:0] ex, input string nm);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    if (r) begin
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = 12'd0;
      exp_q.push_back(12'd0);
    end else begin
      exp_q.push_back(ex);
    end
    name_q.push_back(nm);
  endtask

  // Entry for edge N is checkable right after edge N+1, i.e. once a newer
  // entry exists behind it.
  initial begin : monitor
    logic [11:0] e;
    string       n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (product !== e) begin
          bad++;
          $display("FAIL %s: product=%0d expected=%0d", n, product, e);
        end else begin
          $display("ok   %s: product=%0d", n, product);
        end
      end
    end
  end

  initial begin : stim
    logic [5:0]  ra, rb;
    logic [11:0] rex;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    drive(1, 0, 0, 0, "reset0");
    drive(1, 0, 0, 0, "reset1");
    drive(0, 0, 0, 0, "zero_zero");
    drive(0, 10, 16, 160, "10x16");
    drive(0, 20, 32, 640, "20x32_b2b");
    drive(0, 63, 63, 3969, "63x63_max");
    drive(0, 63, 1, 63, "63x1");
    drive(0, 1, 63, 63, "1x63");
    drive(0, 60, 48, 2880, "60x48");
    drive(0, 0, 63, 0, "0x63");
    drive(0, 63, 0, 0, "63x0");
    drive(0, 37, 29, 1073, "37x29_discarded");
    drive(1, 0, 0, 0, "mid_reset");
    drive(0, 5, 7, 35, "first_after_reset");
    drive(0, 42, 21, 882, "42x21");
    drive(0, 32, 32, 1024, "32x32");
    for (int i = 0; i < 10000; i++) begin
      ra  = 6'($urandom_range(0, 63));
      rb  = 6'($urandom_range(0, 63));
      rex = 12'({6'd0, ra} * {6'd0, rb});
      drive(0, ra, rb, rex, "random");
    end
    drive(0, 0, 0, 0, "tail0");
    drive(0, 0, 0, 0, "tail1");
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL drain: pending=%0d expected<=1", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
